// File: rtl/uart_loader_pkg.sv
// Shared state encoding and framing constants for the UART word loader.
package uart_loader_pkg;
   typedef enum logic [2:0] {S_LEN, S_DATA, S_WRITE, S_CSUM, S_DONE, S_ERR} state_e;
   localparam int unsigned HDR_BYTES  = 4;
   localparam int unsigned WORD_BYTES = 4;
endpackage

// File: rtl/uart_word_loader_if.sv
// Word write port of the UART loader: valid/ready request carrying address and data.
interface uart_word_loader_if #(
   parameter int unsigned ADDR_W = 32
) ();
   logic [ADDR_W-1:0] wr_addr;
   logic [31:0]       wr_data;
   logic              wr_valid;
   logic              wr_ready;

   modport master (output wr_addr, output wr_data, output wr_valid, input wr_ready);
   modport slave  (input wr_addr, input wr_data, input wr_valid, output wr_ready);
endinterface

// File: rtl/uart_byte_fifo.sv
// Byte FIFO with a combinational read port; DEPTH must be a power of 2.
module uart_byte_fifo #(
   parameter int unsigned DEPTH = 8
) (
   input  logic       clk,
   input  logic       rstn,
   input  logic       push,
   input  logic       pop,
   input  logic [7:0] din,
   output logic [7:0] dout,
   output logic       empty,
   output logic       full
);
   localparam int unsigned AW = $clog2(DEPTH);

   logic [7:0]  mem_q [DEPTH];
   logic [AW:0] wr_ptr_q, wr_ptr_d;
   logic [AW:0] rd_ptr_q, rd_ptr_d;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (push) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q[AW-1:0]] <= din;
   end

   assign dout  = mem_q[rd_ptr_q[AW-1:0]];
   assign empty = (wr_ptr_q == rd_ptr_q);
   assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
endmodule

// File: rtl/uart_word_loader.sv
// Sequences uart_rx bytes (length header, LE payload words) into 32-bit writes.
// Optional trailing checksum byte enabled by defining LOADER_CSUM_EN.
module uart_word_loader
   import uart_loader_pkg::*;
#(
   parameter int unsigned       ADDR_W    = 32,
   parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
   parameter int unsigned       DEPTH     = 8
) (
   input  logic                      clk,
   input  logic                      rstn,
   input  logic [7:0]                rdata,
   input  logic                      rdata_ready,
   input  logic                      ferr,
   uart_word_loader_if.master        wr_if,
   output logic                      busy,
   output logic                      done,
   output logic                      err_frame,
   output logic                      err_ovf,
   output logic                      err_csum
);
`ifdef LOADER_CSUM_EN
   localparam state_e AFTER_PAYLOAD = S_CSUM;
`else
   localparam state_e AFTER_PAYLOAD = S_DONE;
`endif

   state_e      state_q, state_d;
   logic [1:0]  cnt_q, cnt_d;
   logic [31:0] len_q, len_d;
   logic [31:0] idx_q, idx_d;
   logic [31:0] word_q, word_d;
   logic        pend_q, pend_d;
   logic        err_frame_q, err_frame_d;
   logic        err_ovf_q, err_ovf_d;
`ifdef LOADER_CSUM_EN
   logic [7:0]  sum_q, sum_d;
   logic        err_csum_q, err_csum_d;
`endif

   logic       fifo_push, fifo_pop, fifo_empty, fifo_full;
   logic [7:0] fifo_dout;
   logic       live, bad, push_req, ovf;

   uart_byte_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .rstn  (rstn),
      .push  (fifo_push),
      .pop   (fifo_pop),
      .din   (rdata),
      .dout  (fifo_dout),
      .empty (fifo_empty),
      .full  (fifo_full)
   );

   always_comb begin
      live      = (state_q != S_ERR);
      bad       = rdata_ready && pend_q;
      fifo_pop  = live && !fifo_empty && (state_q inside {S_LEN, S_DATA, S_CSUM, S_DONE});
      push_req  = live && rdata_ready && !bad;
      // A pop in the same cycle frees a slot, so full alone is not an overflow.
      ovf       = push_req && fifo_full && !fifo_pop;
      fifo_push = push_req && !ovf;
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      len_d       = len_q;
      idx_d       = idx_q;
      word_d      = word_q;
      pend_d      = (pend_q && !rdata_ready) || ferr;
      err_frame_d = err_frame_q;
      err_ovf_d   = err_ovf_q;
`ifdef LOADER_CSUM_EN
      sum_d       = sum_q;
      err_csum_d  = err_csum_q;
`endif
      case (state_q)
         S_LEN: if (fifo_pop) begin
            len_d[{cnt_q, 3'b000} +: 8] = fifo_dout;
            cnt_d = cnt_q + 2'd1;
            if (cnt_q == 2'(HDR_BYTES - 1))
               state_d = ({fifo_dout, len_q[23:0]} != '0) ? S_DATA : AFTER_PAYLOAD;
         end
         S_DATA: if (fifo_pop) begin
            word_d[{cnt_q, 3'b000} +: 8] = fifo_dout;
`ifdef LOADER_CSUM_EN
            sum_d = sum_q + fifo_dout;
`endif
            cnt_d = cnt_q + 2'd1;
            if (cnt_q == 2'(WORD_BYTES - 1)) state_d = S_WRITE;
         end
         S_WRITE: if (wr_if.wr_ready) begin
            idx_d   = idx_q + 32'd1;
            state_d = (idx_q + 32'd1 == len_q) ? AFTER_PAYLOAD : S_DATA;
         end
`ifdef LOADER_CSUM_EN
         S_CSUM: if (fifo_pop) begin
            if (fifo_dout == sum_q) begin
               state_d = S_DONE;
            end else begin
               err_csum_d = 1'b1;
               state_d    = S_ERR;
            end
         end
`endif
         S_DONE: if (fifo_pop) begin
            // The popped byte is already length byte 0 of the next transfer.
            len_d   = {24'h0, fifo_dout};
            cnt_d   = 2'd1;
            idx_d   = '0;
`ifdef LOADER_CSUM_EN
            sum_d   = '0;
`endif
            state_d = S_LEN;
         end
         default: ;
      endcase
      if (live && bad) begin
         err_frame_d = 1'b1;
         state_d     = S_ERR;
      end
      if (ovf) begin
         err_ovf_d = 1'b1;
         state_d   = S_ERR;
      end
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q     <= S_LEN;
         cnt_q       <= '0;
         len_q       <= '0;
         idx_q       <= '0;
         word_q      <= '0;
         pend_q      <= 1'b0;
         err_frame_q <= 1'b0;
         err_ovf_q   <= 1'b0;
`ifdef LOADER_CSUM_EN
         sum_q       <= '0;
         err_csum_q  <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         len_q       <= len_d;
         idx_q       <= idx_d;
         word_q      <= word_d;
         pend_q      <= pend_d;
         err_frame_q <= err_frame_d;
         err_ovf_q   <= err_ovf_d;
`ifdef LOADER_CSUM_EN
         sum_q       <= sum_d;
         err_csum_q  <= err_csum_d;
`endif
      end
   end

   assign wr_if.wr_valid = (state_q == S_WRITE);
   assign wr_if.wr_addr  = wr_if.wr_valid ? BASE_ADDR + ADDR_W'({idx_q, 2'b00}) : '0;
   assign wr_if.wr_data  = wr_if.wr_valid ? word_q : '0;
   assign busy      = ((state_q == S_LEN) && (cnt_q != 2'd0)) ||
                      (state_q inside {S_DATA, S_WRITE, S_CSUM});
   assign done      = (state_q == S_DONE);
   assign err_frame = err_frame_q;
   assign err_ovf   = err_ovf_q;
`ifdef LOADER_CSUM_EN
   assign err_csum  = err_csum_q;
`else
   assign err_csum  = 1'b0;
`endif
endmodule

// File: tb/tb_uart_word_loader.sv
// Directed self-checking bench for uart_word_loader (BASE_ADDR=0x100, DEPTH=8).
module tb_uart_word_loader;
   localparam logic [31:0] BASE = 32'h100;

   logic       clk = 1'b0;
   logic       rstn = 1'b0;
   logic [7:0] rdata = '0;
   logic       rdata_ready = 1'b0;
   logic       ferr = 1'b0;
   logic       busy, done, err_frame, err_ovf, err_csum;

   int unsigned n_assert = 0;
   int unsigned n_fail = 0;
   logic [31:0] wa_q[$];
   logic [31:0] wd_q[$];
   bit          hit;

   uart_word_loader_if #(.ADDR_W(32)) bus ();

   uart_word_loader #(.ADDR_W(32), .BASE_ADDR(BASE), .DEPTH(8)) dut (
      .clk         (clk),
      .rstn        (rstn),
      .rdata       (rdata),
      .rdata_ready (rdata_ready),
      .ferr        (ferr),
      .wr_if       (bus),
      .busy        (busy),
      .done        (done),
      .err_frame   (err_frame),
      .err_ovf     (err_ovf),
      .err_csum    (err_csum)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (rstn && bus.wr_valid && bus.wr_ready) begin
         wa_q.push_back(bus.wr_addr);
         wd_q.push_back(bus.wr_data);
      end
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      @(negedge clk);
      rdata = b;
      rdata_ready = 1'b1;
      @(negedge clk);
      rdata_ready = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rstn = 1'b0;
      repeat (2) @(negedge clk);
      rstn = 1'b1;
   endtask

   task automatic wait_done(input int unsigned max_cycles, output bit ok);
      ok = 1'b0;
      for (int unsigned i = 0; i < max_cycles; i++) begin
         if (done) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
   endtask

   task automatic wait_valid(input int unsigned max_cycles, output bit ok);
      ok = 1'b0;
      for (int unsigned i = 0; i < max_cycles; i++) begin
         if (bus.wr_valid) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      bus.wr_ready = 1'b1;
      do_reset();
      // Reset state
      check("rst_wr_valid", bus.wr_valid, 0);
      check("rst_wr_data", bus.wr_data, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_err_frame", err_frame, 0);
      check("rst_err_ovf", err_ovf, 0);
      check("rst_err_csum", err_csum, 0);

      // T1: single word
      send_byte(8'h01); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
      check("t1_busy_hdr", busy, 1);
      send_byte(8'h78); send_byte(8'h56); send_byte(8'h34); send_byte(8'h12);
`ifdef LOADER_CSUM_EN
      send_byte(8'h14);
`endif
      wait_done(50, hit);
      check("t1_done", hit, 1);
      check("t1_nwr", wa_q.size(), 1);
      if (wa_q.size() >= 1) begin
         check("t1_addr", wa_q[0], BASE);
         check("t1_data", wd_q[0], 32'h12345678);
      end
      check("t1_err_frame", err_frame, 0);
      check("t1_err_ovf", err_ovf, 0);
      check("t1_err_csum", err_csum, 0);
      check("t1_busy_end", busy, 0);

      // T2: zero-length transfer started from S_DONE
      wa_q.delete(); wd_q.delete();
      send_byte(8'h00); send_byte(8'h00);
      check("t2_busy_mid", busy, 1);
      check("t2_done_mid", done, 0);
      send_byte(8'h00); send_byte(8'h00);
`ifdef LOADER_CSUM_EN
      send_byte(8'h00);
`endif
      wait_done(20, hit);
      check("t2_done", hit, 1);
      check("t2_nwr", wa_q.size(), 0);

      // T3: two words with a long write stall; idx restarts at 0
      wa_q.delete(); wd_q.delete();
      bus.wr_ready = 1'b0;
      send_byte(8'h02); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
      send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
      check("t3_valid_t1", bus.wr_valid, 0);
      @(negedge clk);
      check("t3_valid_t2", bus.wr_valid, 1);
      check("t3_addr0", bus.wr_addr, BASE);
      check("t3_data0", bus.wr_data, 32'h04030201);
      send_byte(8'h05); send_byte(8'h06); send_byte(8'h07); send_byte(8'h08);
      repeat (100) @(negedge clk);
      check("t3_valid_hold", bus.wr_valid, 1);
      check("t3_addr_hold", bus.wr_addr, BASE);
      check("t3_data_hold", bus.wr_data, 32'h04030201);
      bus.wr_ready = 1'b1;
`ifdef LOADER_CSUM_EN
      send_byte(8'h24);
`endif
      wait_done(50, hit);
      check("t3_done", hit, 1);
      check("t3_nwr", wa_q.size(), 2);
      if (wa_q.size() >= 2) begin
         check("t3_addr_w0", wa_q[0], BASE);
         check("t3_data_w0", wd_q[0], 32'h04030201);
         check("t3_addr_w1", wa_q[1], BASE + 32'd4);
         check("t3_data_w1", wd_q[1], 32'h08070605);
      end
      check("t3_err_ovf", err_ovf, 0);

      // T4: overflow with writes stalled
      do_reset();
      wa_q.delete(); wd_q.delete();
      bus.wr_ready = 1'b0;
      send_byte(8'h04); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
      for (int unsigned i = 0; i < 12; i++) send_byte(8'(8'h10 + i));
      check("t4_ovf_at12", err_ovf, 0);
      send_byte(8'h1c);
      check("t4_ovf_at13", err_ovf, 1);
      send_byte(8'h1d); send_byte(8'h1e); send_byte(8'h1f);
      bus.wr_ready = 1'b1;
      repeat (20) @(negedge clk);
      check("t4_nwr", wa_q.size(), 0);
      check("t4_busy", busy, 0);
      check("t4_valid", bus.wr_valid, 0);
      check("t4_done", done, 0);

      // T5: frame error before 3rd header byte
      do_reset();
      wa_q.delete(); wd_q.delete();
      send_byte(8'h01); send_byte(8'h00);
      @(negedge clk); ferr = 1'b1;
      @(negedge clk); ferr = 1'b0;
      check("t5_ferr_pending", err_frame, 0);
      send_byte(8'h00);
      check("t5_err_frame", err_frame, 1);
      check("t5_busy", busy, 0);
      send_byte(8'h00); send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
      repeat (10) @(negedge clk);
      check("t5_err_hold", err_frame, 1);
      check("t5_nwr", wa_q.size(), 0);
      do_reset();
      check("t5_err_cleared", err_frame, 0);

      // T6: reset in S_DATA, then a fresh transfer
      send_byte(8'h01); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
      send_byte(8'h78); send_byte(8'h56);
      check("t6_busy_data", busy, 1);
      do_reset();
      check("t6_rst_busy", busy, 0);
      check("t6_rst_valid", bus.wr_valid, 0);
      check("t6_rst_done", done, 0);
      wa_q.delete(); wd_q.delete();
      send_byte(8'h01); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
      send_byte(8'haa); send_byte(8'hbb); send_byte(8'hcc); send_byte(8'hdd);
`ifdef LOADER_CSUM_EN
      send_byte(8'h0e);
`endif
      wait_done(50, hit);
      check("t6_done", hit, 1);
      check("t6_nwr", wa_q.size(), 1);
      if (wa_q.size() >= 1) begin
         check("t6_addr", wa_q[0], BASE);
         check("t6_data", wd_q[0], 32'hddccbbaa);
      end

`ifdef LOADER_CSUM_EN
      // T7: checksum off by one
      send_byte(8'h01); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
      send_byte(8'h78); send_byte(8'h56); send_byte(8'h34); send_byte(8'h12);
      send_byte(8'h15);
      repeat (5) @(negedge clk);
      check("t7_err_csum", err_csum, 1);
      check("t7_done", done, 0);
      check("t7_busy", busy, 0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule

// File: doc/uart_word_loader.md
# uart_word_loader

Byte-stream controller that sits behind `uart_rx` and sequences its output into 32-bit memory writes. It buffers received bytes in a small FIFO, parses a 4-byte length header, assembles little-endian words, and issues them on a valid/ready write port at consecutive word addresses. Frame errors, FIFO overflow and (optionally) checksum mismatch are latched as sticky errors.

## Interface
- `BASE_ADDR`, default 0: byte address of the first written word.
- `ADDR_W`, default 32: width of `wr_addr`.
- `DEPTH`, default 8: byte FIFO depth. Must be a power of 2 and at least 4.
- `clk` in, 1: single clock.
- `rstn` in, 1: reset, synchronous, active-low.
- `rdata` in, 8: received byte from `uart_rx`.
- `rdata_ready` in, 1: one-cycle pulse; `rdata` is valid in this cycle.
- `ferr` in, 1: one-cycle frame-error pulse. It marks the next `rdata_ready` byte as bad.
- `wr_addr` out, ADDR_W: write byte address.
- `wr_data` out, 32: write data.
- `wr_valid` out, 1: write request.
- `wr_ready` in, 1: write accept.
- `busy` out, 1: high in S_LEN when at least 1 header byte has been consumed, and in S_DATA, S_WRITE and S_CSUM.
- `done` out, 1: high while in S_DONE.
- `err_frame`, `err_ovf`, `err_csum` out, 1 each: sticky error flags.

## Operation
- Stream format: 4 length bytes giving N (word count, little-endian), then 4N payload bytes (each word little-endian), then 1 checksum byte if `LOADER_CSUM_EN` is defined.
- FIFO push happens on `rdata_ready`, unless the byte is flagged bad.
- The FSM pops at most 1 byte per cycle, and only when the FIFO is non-empty.
- States:
  - S_LEN: pop 4 bytes into `len`. After the 4th byte, go to S_DATA if N≠0; otherwise go to S_CSUM (macro defined) or S_DONE (macro undefined).
  - S_DATA: pop bytes into the word shift register (first byte lands in [7:0]). The 4th pop moves to S_WRITE.
  - S_WRITE: `wr_valid`=1. On `wr_valid&&wr_ready`: increment `idx`; if `idx+1==N`, go to S_CSUM or S_DONE; otherwise go to S_DATA. No pops occur in S_WRITE.
  - S_CSUM: pop 1 byte and compare it with `sum`. Match goes to S_DONE; mismatch sets `err_csum` and goes to S_ERR.
  - S_DONE: a pop here starts a new transfer. The popped byte is taken as length byte 0 and the FSM moves to S_LEN with 1 byte counted. `idx`, `sum` and `len` are cleared.
  - S_ERR: absorbing. Only `rstn` exits. Pushes and pops stop; `wr_valid`=0.
- Arithmetic:
  - `wr_addr` = BASE_ADDR + {idx,2'b00}, truncated to ADDR_W.
  - `idx` and `len` are 32 bits.
  - `sum` = 8-bit wrap-around sum of all payload bytes (the header is excluded).
- Frame error: a `ferr` pulse sets a pending flag. The next `rdata_ready` byte is dropped, `err_frame` is set, and the FSM goes to S_ERR.
- Overflow: a push into a full FIFO (with no pop in the same cycle) drops the byte, sets `err_ovf`, and the FSM goes to S_ERR.
- Simultaneous push and pop on a full FIFO is legal and is not an overflow.

## Timing
- Reset values:
  - All outputs are 0.
  - FIFO is empty; `idx`, `len`, `sum` and the pending-ferr flag are 0.
  - State is S_LEN.
- Mid-operation reset behaves identically: any in-flight `wr_valid` is dropped the cycle after the `rstn` edge.
- Push is registered: a byte with `rdata_ready` in cycle t is poppable in t+1.
- If the FIFO is empty and the FSM is in S_DATA, the 4th byte's `rdata_ready` in cycle t gives `wr_valid`=1 in cycle t+2.
- While `wr_valid`=1, `wr_addr` and `wr_data` are stable until the handshake. `wr_valid` drops in the cycle after acceptance.
- Minimum of 5 cycles per word with `wr_ready`=1 and bytes pre-buffered (4 pops plus 1 write).
- Error flags assert in the cycle after the offending event.

## Configuration
- `LOADER_CSUM_EN` defined: a trailing checksum byte is expected, the S_CSUM state exists, and `err_csum` is live.
- `LOADER_CSUM_EN` undefined: no checksum byte is expected, the S_CSUM state and `sum` logic are removed, and `err_csum` is tied to 0.

## Structure
- `uart_loader_pkg`: state enum (S_LEN, S_DATA, S_WRITE, S_CSUM, S_DONE, S_ERR) and the `HDR_BYTES`=4 and `WORD_BYTES`=4 constants.
- Sub-module `uart_byte_fifo`: parameter DEPTH; signals push, pop, din, dout, empty, full. Synchronous reset to empty.

## Test plan
- Bytes 01 00 00 00 78 56 34 12 (plus 14 if the macro is defined), `wr_ready`=1 → one write, addr=BASE_ADDR, data=0x12345678; then `done`=1, all error flags 0.
- Bytes 00 00 00 00 (plus 00 if the macro is defined) → no writes; `done`=1.
- N=2, payload 01..08, `wr_ready` low for 100 cycles then high → writes 0x04030201 at BASE_ADDR and 0x08070605 at BASE_ADDR+4; `err_ovf`=0.
- N=4, 16 payload bytes at line rate, `wr_ready` held 0, DEPTH=8 → the 13th payload byte sets `err_ovf`; no further writes; `busy`=0.
- `ferr` pulse before the 3rd header byte → `err_frame`=1, no writes, flag held until `rstn`=0.
- Macro defined, checksum byte off by one → `err_csum`=1 and `done`=0. Separately, `rstn` low during S_DATA → outputs return to 0 and the next 4 bytes are parsed as a fresh header.
